lfsr_random_gen: RTL and testbench

Parametrised pseudo-random number source for game logic: a WIDTH-bit Galois LFSR that produces range-limited draws (0..RANGE-1) through rejection sampling and offers each draw on a valid/ready handshake. It generalises the earlier 8-bit fixed-tap generator in several ways:
- width, taps, output width and range are configurable;
- decorrelation shifts are inserted between draws;
- a zero seed is substituted so the register cannot lock up;
- consumers are flow-controlled.

It sits between the seed source (e.g. free-running counter captured on a keypress) and any block needing random picks.

---
 rtl/lfsr_pkg.sv | 36 +++
 rtl/lfsr_core.sv | 73 +++++++
 rtl/lfsr_random_gen.sv | 160 ++++++++++++++++
 tb/tb_lfsr_random_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared definitions for the LFSR random generator: FSM state
//               encoding, default Galois tap masks for common widths and the
//               single-step Galois shift function.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

  // Widest LFSR the shift helper supports; narrower registers are
  // zero-extended into it and truncated back afterwards.
  localparam int LFSR_MAX_WIDTH = 64;

  // Default Galois feedback masks (maximal-length) for common widths.
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'h80200003;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OFFER = 2'd2
  } fsm_state_e;

  // One Galois step: shift right, fold the taps in when the bit leaving the
  // register is a one.
  function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_shift(
    input logic [LFSR_MAX_WIDTH-1:0] state,
    input logic [LFSR_MAX_WIDTH-1:0] taps
  );
    return (state >> 1) ^ (state[0] ? taps : '0);
  endfunction

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_core
// Description : LFSR state register with shift and seed-load logic. A zero
//               seed is replaced by DEFAULT_SEED so the register can never
//               enter the all-zero lock-up state.
// Revision    : 1.0 - initial release
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   shift_i     in   advance the register by one Galois step
//   load_i      in   load seed_i (wins over shift_i)
//   seed_i      in   seed value
//   state_o     out  current state register
//   cand_o      out  low OUT_WIDTH bits of the state the next shift produces
//   seed_sub_o  out  one-cycle pulse: a zero seed was substituted
// ============================================================================
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = TAPS_16,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1,
  parameter int               OUT_WIDTH    = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 shift_i,
  input  logic                 load_i,
  input  logic [WIDTH-1:0]     seed_i,
  output logic [WIDTH-1:0]     state_o,
  output logic [OUT_WIDTH-1:0] cand_o,
  output logic                 seed_sub_o
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] shifted;
  logic             sub_q, sub_d;
  logic             seed_zero;

  assign shifted   = WIDTH'(lfsr_shift(LFSR_MAX_WIDTH'(state_q), LFSR_MAX_WIDTH'(TAPS)));
  assign seed_zero = (seed_i == '0);

  // The candidate is judged on the value the register is about to take, so
  // the range check and the shift land on the same clock edge.
  assign cand_o = shifted[OUT_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    sub_d   = 1'b0;
    if (load_i) begin
      state_d = seed_zero ? DEFAULT_SEED : seed_i;
      sub_d   = seed_zero;
    end else if (shift_i) begin
      state_d = shifted;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= DEFAULT_SEED;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
    end
  end

  assign state_o    = state_q;
  assign seed_sub_o = sub_q;

endmodule : lfsr_core
`default_nettype wire

// File: rtl/lfsr_random_gen.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_random_gen
// Description : Range-limited pseudo-random draws from a Galois LFSR. Each
//               candidate is taken after STEPS shifts; candidates >= RANGE
//               are rejected and a fresh candidate is built. Accepted draws
//               are offered on a valid/ready handshake.
// Revision    : 1.0 - initial release
// Ports:
//   clock            in   rising-edge clock
//   reset            in   asynchronous active-low reset
//   enable           in   permits shifting/drawing
//   load_seed        in   one-cycle seed load request (highest priority)
//   seed             in   seed value, sampled with load_seed
//   rand_valid       out  draw available
//   rand_ready       in   consumer accepts draw
//   randnum          out  current draw, 0..RANGE-1
//   draw_rejected    out  one-cycle pulse: candidate >= RANGE discarded
//   seed_substituted out  one-cycle pulse: zero seed replaced
//   lfsr_state       out  debug view of the state register
// ============================================================================
module lfsr_random_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = TAPS_16,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1,
  parameter int               OUT_WIDTH    = 3,
  parameter int               RANGE        = 5,
  parameter int               STEPS        = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load_seed,
  input  logic [WIDTH-1:0]     seed,
  output logic                 rand_valid,
  input  logic                 rand_ready,
  output logic [OUT_WIDTH-1:0] randnum,
  output logic                 draw_rejected,
  output logic                 seed_substituted,
  output logic [WIDTH-1:0]     lfsr_state
);

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  if (WIDTH < 4 || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
    $error("lfsr_random_gen: WIDTH must be in 4..64");
  end
  if (OUT_WIDTH < 1 || OUT_WIDTH > WIDTH) begin : g_bad_out_width
    $error("lfsr_random_gen: OUT_WIDTH must be in 1..WIDTH");
  end
  if (RANGE < 1 || (OUT_WIDTH < 31 && RANGE > (1 << OUT_WIDTH))) begin : g_bad_range
    $error("lfsr_random_gen: RANGE must be in 1..2**OUT_WIDTH");
  end
  if (STEPS < 1) begin : g_bad_steps
    $error("lfsr_random_gen: STEPS must be at least 1");
  end
  if (DEFAULT_SEED == '0) begin : g_bad_seed
    $error("lfsr_random_gen: DEFAULT_SEED must be nonzero");
  end

  localparam int                 CNT_W     = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(STEPS - 1);
  // One extra bit so RANGE == 2**OUT_WIDTH is representable.
  localparam logic [OUT_WIDTH:0] RANGE_LIM = (OUT_WIDTH + 1)'(RANGE);

  fsm_state_e           fsm_q;
  logic [CNT_W-1:0]     count_q;
  logic [OUT_WIDTH-1:0] randnum_q;
  logic                 valid_q;
  logic                 rej_q;

  logic                 shift_en;
  logic [OUT_WIDTH-1:0] cand;
  logic                 cand_ok;

  // A seed load owns the state register for that cycle, so no shift then.
  assign shift_en = (fsm_q == SHIFT) && enable && !load_seed;
  assign cand_ok  = ({1'b0, cand} < RANGE_LIM);

  lfsr_core #(
    .WIDTH        (WIDTH),
    .TAPS         (TAPS),
    .DEFAULT_SEED (DEFAULT_SEED),
    .OUT_WIDTH    (OUT_WIDTH)
  ) u_core (
    .clock      (clock),
    .reset      (reset),
    .shift_i    (shift_en),
    .load_i     (load_seed),
    .seed_i     (seed),
    .state_o    (lfsr_state),
    .cand_o     (cand),
    .seed_sub_o (seed_substituted)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_q     <= IDLE;
      count_q   <= '0;
      randnum_q <= '0;
      valid_q   <= 1'b0;
      rej_q     <= 1'b0;
    end else begin
      rej_q <= 1'b0;
      if (load_seed) begin
        // Any offered draw is dropped, even if rand_ready is high now.
        valid_q <= 1'b0;
        count_q <= '0;
        fsm_q   <= enable ? SHIFT : IDLE;
      end else begin
        case (fsm_q)
          IDLE: begin
            if (enable) begin
              fsm_q   <= SHIFT;
              count_q <= '0;
            end
          end
          SHIFT: begin
            if (!enable) begin
              fsm_q <= IDLE;
            end else if (count_q == LAST_STEP) begin
              count_q <= '0;
              if (cand_ok) begin
                randnum_q <= cand;
                valid_q   <= 1'b1;
                fsm_q     <= OFFER;
              end else begin
                rej_q <= 1'b1;
              end
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
          OFFER: begin
            // enable is deliberately ignored until the draw is taken.
            if (rand_ready) begin
              valid_q <= 1'b0;
              count_q <= '0;
              fsm_q   <= enable ? SHIFT : IDLE;
            end
          end
          default: begin
            fsm_q   <= IDLE;
            count_q <= '0;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rand_valid    = valid_q;
  assign randnum       = randnum_q;
  assign draw_rejected = rej_q;

endmodule : lfsr_random_gen
`default_nettype wire

// File: tb/tb_lfsr_random_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_random_gen
// Description : Self-checking bench for lfsr_random_gen with default
//               parameters. A draw-level reference model predicts each draw,
//               its rejection count, its latency and the resulting state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_random_gen;

  localparam int          WIDTH     = 16;
  localparam int          OUT_WIDTH = 3;
  localparam int          RANGE     = 5;
  localparam int          STEPS     = 3;
  localparam int unsigned TAPS_V    = 32'hB400;
  localparam int unsigned DEF_SEED  = 32'hACE1;

  logic                 clock;
  logic                 reset;
  logic                 enable;
  logic                 load_seed;
  logic [WIDTH-1:0]     seed;
  logic                 rand_valid;
  logic                 rand_ready;
  logic [OUT_WIDTH-1:0] randnum;
  logic                 draw_rejected;
  logic                 seed_substituted;
  logic [WIDTH-1:0]     lfsr_state;

  int          vectors = 0;
  int          errors  = 0;
  int unsigned ms;       // model LFSR state
  int unsigned exp_rn;   // model value of the current draw

  lfsr_random_gen dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .load_seed        (load_seed),
    .seed             (seed),
    .rand_valid       (rand_valid),
    .rand_ready       (rand_ready),
    .randnum          (randnum),
    .draw_rejected    (draw_rejected),
    .seed_substituted (seed_substituted),
    .lfsr_state       (lfsr_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One Galois step in plain arithmetic.
  function automatic int unsigned step(input int unsigned s);
    return (s / 2) ^ (((s % 2) == 1) ? TAPS_V : 0);
  endfunction

  // Draw-level model: keep building candidates until one falls in range.
  function automatic int unsigned model_draw(input int unsigned s, output int unsigned ns,
                                             output int rej);
    int unsigned v;
    rej = 0;
    v   = s;
    for (int t = 0; t < 1000; t++) begin
      for (int k = 0; k < STEPS; k++) v = step(v);
      if ((v % (1 << OUT_WIDTH)) < RANGE) begin
        ns = v;
        return v % (1 << OUT_WIDTH);
      end
      rej++;
    end
    ns = v;
    return 0;
  endfunction

  // Wait for the next offered draw and check it against the model. start is
  // the number of cycles already elapsed since the triggering event.
  task automatic do_draw(input int start, input string tag);
    int          rej;
    int          cyc;
    int          seen;
    int unsigned ns;
    exp_rn = model_draw(ms, ns, rej);
    ms     = ns;
    cyc    = start;
    seen   = 0;
    do begin
      @(negedge clock);
      cyc++;
      if (draw_rejected) seen++;
    end while (!rand_valid && cyc < 400);
    chk({tag, "_valid"},   rand_valid, 1);
    chk({tag, "_randnum"}, randnum, exp_rn);
    chk({tag, "_latency"}, cyc, 1 + STEPS * (1 + rej));
    chk({tag, "_rejects"}, seen, rej);
    chk({tag, "_state"},   lfsr_state, ms);
  endtask

  // Present a seed for one cycle and check its immediate effects.
  task automatic pulse_load(input logic [WIDTH-1:0] s);
    load_seed = 1'b1;
    seed      = s;
    @(negedge clock);
    load_seed = 1'b0;
    seed      = 16'($urandom);
    ms        = (s == 0) ? DEF_SEED : 32'(s);
    chk("load_sub",   seed_substituted, (s == 0));
    chk("load_state", lfsr_state, ms);
    chk("load_drop",  rand_valid, 0);
  endtask

  initial begin
    reset      = 1'b0;
    enable     = 1'b0;
    load_seed  = 1'b0;
    seed       = '0;
    rand_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clock);
    chk("rst_valid", rand_valid, 0);
    chk("rst_randnum", randnum, 0);
    chk("rst_rej", draw_rejected, 0);
    chk("rst_sub", seed_substituted, 0);
    chk("rst_state", lfsr_state, DEF_SEED);

    // First two draws from the default seed
    enable     = 1'b1;
    rand_ready = 1'b1;
    reset      = 1'b1;
    ms         = DEF_SEED;
    do_draw(0, "first");
    chk("first_const", randnum, 4);
    do_draw(0, "second");
    chk("second_const", randnum, 3);
    chk("second_state_const", lfsr_state, 16'hB313);

    // Load during OFFER with rand_ready high: drop, then rejection path
    pulse_load(16'h0038);
    do_draw(1, "seed38");
    chk("seed38_const", randnum, 0);
    chk("seed38_state_const", lfsr_state, 16'hC300);

    // Hold rand_ready low in OFFER while toggling enable
    rand_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      enable = 1'($urandom);
      @(negedge clock);
      chk("hold_valid", rand_valid, 1);
      chk("hold_randnum", randnum, exp_rn);
      chk("hold_state", lfsr_state, ms);
    end
    enable     = 1'b1;
    rand_ready = 1'b1;
    do_draw(0, "after_hold");

    // Zero seed substitution
    pulse_load(16'h0000);
    do_draw(1, "seed0");
    chk("seed0_const", randnum, 4);
    chk("seed0_sub_low", seed_substituted, 0);

    // Asynchronous reset in the middle of SHIFT
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async_valid", rand_valid, 0);
    chk("async_randnum", randnum, 0);
    chk("async_rej", draw_rejected, 0);
    chk("async_state", lfsr_state, DEF_SEED);
    @(negedge clock);
    reset = 1'b1;
    ms    = DEF_SEED;
    do_draw(0, "post_rst");

    // Randomized directed steps, each starting with a draw on offer
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          enable     = 1'b1;
          rand_ready = 1'b1;
          do_draw(0, "r_accept");
        end
        1: begin
          rand_ready = 1'b0;
          for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
            enable = 1'($urandom);
            @(negedge clock);
            chk("r_hold_valid", rand_valid, 1);
            chk("r_hold_num", randnum, exp_rn);
            chk("r_hold_state", lfsr_state, ms);
          end
          enable     = 1'b1;
          rand_ready = 1'b1;
          do_draw(0, "r_held");
        end
        2: begin
          rand_ready = 1'b1;
          enable     = 1'b0;
          @(negedge clock);
          chk("r_idle_taken", rand_valid, 0);
          for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
            @(negedge clock);
            chk("r_idle_state", lfsr_state, ms);
          end
          enable = 1'b1;
          do_draw(0, "r_idle");
        end
        default: begin
          enable     = 1'b1;
          rand_ready = 1'($urandom);
          pulse_load(($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
          do_draw(1, "r_load");
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_lfsr_random_gen
`default_nettype wire
